// File: rtl/eth_regs_pkg.sv
// Shared definitions for the Ethernet register block (read and write sides).
package eth_regs_pkg;

  // Register address map
  localparam logic [3:0] ADDR_MAC0   = 4'h0;
  localparam logic [3:0] ADDR_MAC1   = 4'h1;
  localparam logic [3:0] ADDR_MAC2   = 4'h2;
  localparam logic [3:0] ADDR_MC0    = 4'h3;
  localparam logic [3:0] ADDR_MC1    = 4'h4;
  localparam logic [3:0] ADDR_MC2    = 4'h5;
  localparam logic [3:0] ADDR_TXALR  = 4'h6;
  localparam logic [3:0] ADDR_MINLR  = 4'h7;
  localparam logic [3:0] ADDR_MAXLR  = 4'h8;
  localparam logic [3:0] ADDR_CR     = 4'h9;
  localparam logic [3:0] ADDR_RXCR   = 4'hA;
  localparam logic [3:0] ADDR_TXDDR  = 4'hB;
  localparam logic [3:0] ADDR_RXDTR  = 4'hC;
  localparam logic [3:0] ADDR_RXDWTR = 4'hD;
  localparam logic [3:0] ADDR_STATUS = 4'hE;
  localparam logic [3:0] ADDR_RXCNT  = 4'hF;

  // Sticky status bit positions
  localparam int unsigned STAT_TX_DONE = 0;
  localparam int unsigned STAT_RX_DONE = 1;
  localparam int unsigned STAT_RX_ERR  = 2;
  localparam int unsigned STAT_W       = 3;

  // Host read handshake states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAPT = 2'd1,
    ST_ACK  = 2'd2,
    ST_WAIT = 2'd3
  } rd_state_t;

  // Sticky update: clear what was read, new events always win
  function automatic logic [STAT_W-1:0] status_next(
    input logic [STAT_W-1:0] cur,
    input logic [STAT_W-1:0] clr,
    input logic [STAT_W-1:0] evt
  );
    return (cur & ~clr) | evt;
  endfunction

endpackage

// File: rtl/eth_evt_cnt.sv
// Saturating 16-bit event counter, cleared on read; an event in the
// clearing cycle is counted as the first event of the new interval.
module eth_evt_cnt (
  input  logic        clk,
  input  logic        res,
  input  logic        i_inc,
  input  logic        i_clr,
  output logic [15:0] o_cnt
);

  logic [15:0] r_cnt;

  // Count, saturate at all-ones, clear with increment taking priority
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= i_inc ? 16'd1 : '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/eth_regs_rd.sv
// Host read side of the Ethernet register block: 4-state read handshake,
// MAC/multicast snapshot shadows, sticky status with IRQ, rx frame counter.
module eth_regs_rd
  import eth_regs_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             rd_req,
  input  logic [3:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_ack,
  input  logic [47:0]      mac_adr,
  input  logic [47:0]      multicast_adr,
  input  logic [4:0]       txalr,
  input  logic [9:0]       minlr,
  input  logic [12:0]      maxlr,
  input  logic             cr,
  input  logic [11:0]      rxcr,
  input  logic [1:0]       txddr,
  input  logic [7:0]       rxdtr,
  input  logic [15:0]      rxdwtr,
  input  logic             tx_done,
  input  logic             rx_done,
  input  logic             rx_err,
  output logic             irq
);

  rd_state_t          r_state;
  rd_state_t          w_next;
  logic               w_accept;
  logic               w_load;
  logic [3:0]         r_addr;
  logic [WIDTH-1:0]   r_rd_data;
  logic               r_rd_ack;
  logic [31:0]        r_mac_sh;
  logic [31:0]        r_mc_sh;
  logic [STAT_W-1:0]  r_status;
  logic [STAT_W-1:0]  w_evt;
  logic [STAT_W-1:0]  w_stat_clr;
  logic               w_cnt_clr;
  logic [15:0]        w_cnt;
  logic [15:0]        w_sel;
  logic               r_irq;

  // State register
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and per-state strobes
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_load   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rd_req) begin
          w_next   = ST_CAPT;
          w_accept = 1'b1;
        end
      end
      ST_CAPT: begin
        w_next = ST_ACK;
        w_load = 1'b1;
      end
      ST_ACK: begin
        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (!rd_req) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Latch the address when a request is accepted
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_addr <= '0;
    end else if (w_accept) begin
      r_addr <= rd_addr;
    end
  end

  // Read data select, narrow fields zero-extended
  always_comb begin
    w_sel = '0;
    case (r_addr)
      ADDR_MAC0:   w_sel = mac_adr[15:0];
      ADDR_MAC1:   w_sel = r_mac_sh[15:0];
      ADDR_MAC2:   w_sel = r_mac_sh[31:16];
      ADDR_MC0:    w_sel = multicast_adr[15:0];
      ADDR_MC1:    w_sel = r_mc_sh[15:0];
      ADDR_MC2:    w_sel = r_mc_sh[31:16];
      ADDR_TXALR:  w_sel = 16'(txalr);
      ADDR_MINLR:  w_sel = 16'(minlr);
      ADDR_MAXLR:  w_sel = 16'(maxlr);
      ADDR_CR:     w_sel = 16'(cr);
      ADDR_RXCR:   w_sel = 16'(rxcr);
      ADDR_TXDDR:  w_sel = 16'(txddr);
      ADDR_RXDTR:  w_sel = 16'(rxdtr);
      ADDR_RXDWTR: w_sel = rxdwtr;
      ADDR_STATUS: w_sel = 16'(r_status);
      ADDR_RXCNT:  w_sel = w_cnt;
      default:     w_sel = '0;
    endcase
  end

  // Clear-on-read strobes take effect only on the capture edge
  always_comb begin
    w_stat_clr = '0;
    w_cnt_clr  = 1'b0;
    if (w_load && (r_addr == ADDR_STATUS)) begin
      w_stat_clr = r_status;
    end
    if (w_load && (r_addr == ADDR_RXCNT)) begin
      w_cnt_clr = 1'b1;
    end
  end

  // Output data register, held until the next capture
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_rd_data <= '0;
    end else if (w_load) begin
      r_rd_data <= WIDTH'(w_sel);
    end
  end

  // Completion strobe registered from ACK so it appears two edges after acceptance
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_rd_ack <= 1'b0;
    end else begin
      r_rd_ack <= (r_state == ST_ACK);
    end
  end

  // Upper address words snapshotted when the low word is read
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_mac_sh <= '0;
      r_mc_sh  <= '0;
    end else if (w_load) begin
      if (r_addr == ADDR_MAC0) begin
        r_mac_sh <= mac_adr[47:16];
      end
      if (r_addr == ADDR_MC0) begin
        r_mc_sh <= multicast_adr[47:16];
      end
    end
  end

  always_comb begin
    w_evt               = '0;
    w_evt[STAT_TX_DONE] = tx_done;
    w_evt[STAT_RX_DONE] = rx_done;
    w_evt[STAT_RX_ERR]  = rx_err;
  end

  // Sticky status, events captured regardless of handshake state
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_status <= '0;
    end else begin
      r_status <= status_next(r_status, w_stat_clr, w_evt);
    end
  end

  // Interrupt registered from the status register
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |r_status;
    end
  end

  eth_evt_cnt u_rx_cnt (
    .clk   (clk),
    .res   (res),
    .i_inc (rx_done),
    .i_clr (w_cnt_clr),
    .o_cnt (w_cnt)
  );

  assign rd_data = r_rd_data;
  assign rd_ack  = r_rd_ack;
  assign irq     = r_irq;

endmodule

// File: tb/tb_eth_regs_rd.sv
// Scoreboard bench for eth_regs_rd: driver keeps a register-level model and
// queues expected read results; a negedge monitor checks each rd_ack.
module tb_eth_regs_rd;

  logic        clk = 1'b0;
  logic        res;
  logic        rd_req;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_ack;
  logic [47:0] mac_adr;
  logic [47:0] multicast_adr;
  logic [4:0]  txalr;
  logic [9:0]  minlr;
  logic [12:0] maxlr;
  logic        cr;
  logic [11:0] rxcr;
  logic [1:0]  txddr;
  logic [7:0]  rxdtr;
  logic [15:0] rxdwtr;
  logic        tx_done;
  logic        rx_done;
  logic        rx_err;
  logic        irq;

  eth_regs_rd #(.WIDTH(16)) dut (
    .clk           (clk),
    .res           (res),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_ack        (rd_ack),
    .mac_adr       (mac_adr),
    .multicast_adr (multicast_adr),
    .txalr         (txalr),
    .minlr         (minlr),
    .maxlr         (maxlr),
    .cr            (cr),
    .rxcr          (rxcr),
    .txddr         (txddr),
    .rxdtr         (rxdtr),
    .rxdwtr        (rxdwtr),
    .tx_done       (tx_done),
    .rx_done       (rx_done),
    .rx_err        (rx_err),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [15:0] data;
    int unsigned edge_no;
    logic [3:0]  addr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [2:0]  m_status;
  int          m_cnt;
  logic        m_irq;
  logic [31:0] m_mac_sh;
  logic [31:0] m_mc_sh;
  logic [15:0] m_rd_data;
  logic [2:0]  pend_clr_stat;
  logic        pend_clr_cnt;
  logic        pend_load;
  logic [15:0] pend_val;

  // Monitor: every rd_ack must match the oldest queued read, data and timing
  always @(negedge clk) begin
    exp_t e;
    if (rd_ack) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected edge=%0d data=%h required=no ack", edge_cnt, rd_data);
      end else begin
        e = sb.pop_front();
        if (rd_data !== e.data || edge_cnt != e.edge_no) begin
          errors++;
          $display("FAIL read_addr%h data=%h edge=%0d required data=%h edge=%0d",
                   e.addr, rd_data, edge_cnt, e.data, e.edge_no);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h time=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_status      = '0;
    m_cnt         = 0;
    m_irq         = 1'b0;
    m_mac_sh      = '0;
    m_mc_sh       = '0;
    m_rd_data     = '0;
    pend_clr_stat = '0;
    pend_clr_cnt  = 1'b0;
    pend_load     = 1'b0;
    pend_val      = '0;
  endtask

  // One clock with event pulses {rx_err, rx_done, tx_done}; model advances with it
  task automatic tick(input logic [2:0] ev);
    {rx_err, rx_done, tx_done} = ev;
    @(posedge clk);
    if (res) begin
      model_reset();
    end else begin
      m_irq    = (m_status != 3'b000);
      m_status = (m_status & ~pend_clr_stat) | ev;
      if (pend_clr_cnt) m_cnt = ev[1] ? 1 : 0;
      else if (ev[1] && m_cnt < 65535) m_cnt++;
      if (pend_load) m_rd_data = pend_val;
    end
    pend_clr_stat = '0;
    pend_clr_cnt  = 1'b0;
    pend_load     = 1'b0;
    #1;
    {rx_err, rx_done, tx_done} = 3'b000;
    check("irq", {15'd0, irq}, {15'd0, m_irq});
    check("rd_data_hold", rd_data, m_rd_data);
  endtask

  // Value the register map returns for an address, plus its read side effects
  task automatic plan_read(input logic [3:0] a);
    logic [15:0] v;
    case (a)
      4'h0: begin v = mac_adr[15:0]; m_mac_sh = mac_adr[47:16]; end
      4'h1: v = m_mac_sh[15:0];
      4'h2: v = m_mac_sh[31:16];
      4'h3: begin v = multicast_adr[15:0]; m_mc_sh = multicast_adr[47:16]; end
      4'h4: v = m_mc_sh[15:0];
      4'h5: v = m_mc_sh[31:16];
      4'h6: v = {11'd0, txalr};
      4'h7: v = {6'd0, minlr};
      4'h8: v = {3'd0, maxlr};
      4'h9: v = {15'd0, cr};
      4'hA: v = {4'd0, rxcr};
      4'hB: v = {14'd0, txddr};
      4'hC: v = {8'd0, rxdtr};
      4'hD: v = rxdwtr;
      4'hE: begin v = {13'd0, m_status}; pend_clr_stat = m_status; end
      default: begin v = m_cnt[15:0]; pend_clr_cnt = 1'b1; end
    endcase
    pend_load = 1'b1;
    pend_val  = v;
  endtask

  function automatic logic [2:0] rnd_ev(input bit en);
    logic [2:0] r;
    r = '0;
    if (en) begin
      for (int unsigned b = 0; b < 3; b++) r[b] = ($urandom_range(0, 3) == 0);
    end
    return r;
  endfunction

  // Full read: rd_req held for 'hold' edges (>=2), ev_clr applied on the capture edge
  task automatic do_read(input logic [3:0] a, input int hold, input logic [2:0] ev_clr, input bit rnd);
    exp_t e;
    rd_addr = a;
    rd_req  = 1'b1;
    tick(rnd_ev(rnd));
    plan_read(a);
    e.data    = pend_val;
    e.edge_no = edge_cnt + 2;
    e.addr    = a;
    sb.push_back(e);
    rd_addr = 4'($urandom_range(0, 15));
    tick(ev_clr);
    for (int i = 2; i < hold; i++) tick(rnd_ev(rnd));
    rd_req = 1'b0;
    for (int i = 0; i < 3; i++) tick(rnd_ev(rnd));
  endtask

  task automatic randomize_regs();
    mac_adr       = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    multicast_adr = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    txalr         = 5'($urandom);
    minlr         = 10'($urandom);
    maxlr         = 13'($urandom);
    cr            = 1'($urandom);
    rxcr          = 12'($urandom);
    txddr         = 2'($urandom);
    rxdtr         = 8'($urandom);
    rxdwtr        = 16'($urandom);
  endtask

  initial begin
    res = 1'b1;
    rd_req = 1'b0;
    rd_addr = '0;
    {rx_err, rx_done, tx_done} = 3'b000;
    mac_adr = 48'h1122_3344_5566;
    multicast_adr = 48'h0A0B_0C0D_0E0F;
    txalr = 5'h15; minlr = 10'h2A5; maxlr = 13'h1ABC; cr = 1'b1;
    rxcr = 12'hF0E; txddr = 2'h2; rxdtr = 8'h5A; rxdwtr = 16'hBEEF;
    model_reset();
    tick(3'b000);
    tick(3'b000);
    check("reset_ack", {15'd0, rd_ack}, 16'h0000);
    res = 1'b0;

    // Shadows read before any snapshot return zero
    do_read(4'h1, 2, 3'b000, 0);
    do_read(4'h5, 2, 3'b000, 0);
    // Split MAC read and snapshot hold
    do_read(4'h0, 2, 3'b000, 0);
    do_read(4'h1, 2, 3'b000, 0);
    do_read(4'h2, 2, 3'b000, 0);
    do_read(4'h0, 2, 3'b000, 0);
    mac_adr = 48'hAABB_CCDD_EEFF;
    do_read(4'h1, 2, 3'b000, 0);
    do_read(4'h2, 2, 3'b000, 0);
    do_read(4'h3, 2, 3'b000, 0);
    do_read(4'h4, 2, 3'b000, 0);
    do_read(4'h5, 2, 3'b000, 0);
    for (int unsigned a = 6; a < 14; a++) do_read(4'(a), 2, 3'b000, 0);

    // Sticky status with irq, and event in the clearing cycle
    tick(3'b100);
    tick(3'b000);
    tick(3'b000);
    check("irq_before_clear", {15'd0, irq}, 16'h0001);
    do_read(4'hE, 2, 3'b000, 0);
    check("irq_after_clear", {15'd0, irq}, 16'h0000);
    tick(3'b100);
    do_read(4'hE, 2, 3'b100, 0);
    do_read(4'hE, 2, 3'b000, 0);
    do_read(4'hE, 2, 3'b000, 0);

    // Counter saturation and clear with concurrent rx_done
    for (int i = 0; i < 70000; i++) tick(3'b010);
    do_read(4'hF, 2, 3'b000, 0);
    do_read(4'hF, 2, 3'b000, 0);
    do_read(4'hF, 2, 3'b010, 0);
    do_read(4'hF, 2, 3'b000, 0);
    do_read(4'hE, 2, 3'b000, 0);

    // Long-held request gives exactly one ack
    do_read(4'hD, 10, 3'b000, 0);

    // Reset while in CAPT aborts the read
    tick(3'b001);
    rd_addr = 4'hE;
    rd_req  = 1'b1;
    tick(3'b000);
    res = 1'b1;
    model_reset();
    #1;
    check("abort_ack", {15'd0, rd_ack}, 16'h0000);
    check("abort_data", rd_data, 16'h0000);
    check("abort_irq", {15'd0, irq}, 16'h0000);
    rd_req = 1'b0;
    tick(3'b000);
    tick(3'b000);
    res = 1'b0;
    do_read(4'hE, 2, 3'b000, 0);
    do_read(4'h2, 2, 3'b000, 0);
    do_read(4'hF, 2, 3'b000, 0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) randomize_regs();
      do_read(4'($urandom_range(0, 15)), $urandom_range(2, 4), rnd_ev(1), 1);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick(rnd_ev(1));
    end

    tick(3'b000);
    tick(3'b000);
    check("scoreboard_empty", 16'(sb.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
